// File: rtl/freq_meter_8ch.sv
// freq_meter_8ch: eight-channel frequency meter.
// Each channel counts synchronized rising edges of sig_in[N] over a gate
// window of GATE_CYCLES clock cycles. Windows repeat back-to-back while
// enable is high. The count of each completed window is latched to
// freq_N, and data_valid pulses for one cycle.
//
// Ports
//   clk_clk        system clock
//   reset_reset    synchronous, active-high reset
//   enable         run (1) / stop (0) the measurement
//   sig_in[7:0]    asynchronous frequency inputs, bit N = channel N
//   freq_0..7      edge count of the last completed window (saturating)
//   ovf[7:0]       per-channel saturation flag of the last completed window
//   data_valid     one-cycle pulse when freq_N / ovf update
//   busy           high while in ARM or COUNT
//
// state | meaning
// IDLE  | stopped; gate and channel counters held at zero
// ARM   | 3-cycle synchronizer flush; edges ignored
// COUNT | gate window running; terminal cycle latches results and restarts
module freq_meter_8ch #(
   parameter int unsigned GATE_CYCLES = 50000000,
   parameter logic [23:0] SAT_VAL     = 24'hFFFFFF
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic        enable,
   input  logic [7:0]  sig_in,
   output logic [23:0] freq_0,
   output logic [23:0] freq_1,
   output logic [23:0] freq_2,
   output logic [23:0] freq_3,
   output logic [23:0] freq_4,
   output logic [23:0] freq_5,
   output logic [23:0] freq_6,
   output logic [23:0] freq_7,
   output logic [7:0]  ovf,
   output logic        data_valid,
   output logic        busy
);

   localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

   state_t        state;
   logic [1:0]    arm_cnt;
   logic [GW-1:0] gate_cnt;
   logic [23:0]   cnt     [8];
   logic [23:0]   freq_r  [8];
   logic [7:0]    ovf_int;

   logic [7:0]    sync_a;
   logic [7:0]    sync_b;
   logic [7:0]    sync_d;
   logic [7:0]    edge_hit;

   logic [24:0]   sum     [8];
   logic [23:0]   sat_sum [8];
   logic [7:0]    ovf_nxt;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         sync_a <= '0;
         sync_b <= '0;
         sync_d <= '0;
      end else begin
         sync_a <= sig_in;
         sync_b <= sync_a;
         sync_d <= sync_b;
      end
   end

   assign edge_hit = sync_b & ~sync_d;

   // Saturating next count; the sum is one bit wider so cnt==SAT_VAL plus
   // an edge is seen as reaching saturation rather than wrapping.
   always_comb begin
      ovf_nxt = '0;
      for (int i = 0; i < 8; i++) begin
         sum[i]     = {1'b0, cnt[i]} + 25'(edge_hit[i]);
         sat_sum[i] = sum[i][23:0];
         if (sum[i] >= {1'b0, SAT_VAL}) begin
            sat_sum[i] = SAT_VAL;
            ovf_nxt[i] = 1'b1;
         end else begin
            ovf_nxt[i] = ovf_int[i];
         end
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state      <= IDLE;
         arm_cnt    <= '0;
         gate_cnt   <= '0;
         ovf_int    <= '0;
         ovf        <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            cnt[i]    <= '0;
            freq_r[i] <= '0;
         end
      end else begin
         data_valid <= 1'b0;
         case (state)
            IDLE: begin
               arm_cnt  <= '0;
               gate_cnt <= '0;
               ovf_int  <= '0;
               for (int i = 0; i < 8; i++) cnt[i] <= '0;
               if (enable) begin
                  state <= ARM;
                  busy  <= 1'b1;
               end else begin
                  busy  <= 1'b0;
               end
            end

            ARM: begin
               gate_cnt <= '0;
               ovf_int  <= '0;
               for (int i = 0; i < 8; i++) cnt[i] <= '0;
               if (!enable) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (arm_cnt == 2'd2) begin
                  state   <= COUNT;
                  arm_cnt <= '0;
               end else begin
                  arm_cnt <= arm_cnt + 2'd1;
               end
            end

            COUNT: begin
               if (gate_cnt == GATE_LAST) begin
                  // Terminal cycle: its own edge joins the closing window,
                  // and the next window starts on the following cycle.
                  for (int i = 0; i < 8; i++) begin
                     freq_r[i] <= sat_sum[i];
                     cnt[i]    <= '0;
                  end
                  ovf        <= ovf_nxt;
                  ovf_int    <= '0;
                  data_valid <= 1'b1;
                  gate_cnt   <= '0;
                  if (!enable) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else if (!enable) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gate_cnt <= gate_cnt + GW'(1);
                  ovf_int  <= ovf_nxt;
                  for (int i = 0; i < 8; i++) cnt[i] <= sat_sum[i];
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign freq_0 = freq_r[0];
   assign freq_1 = freq_r[1];
   assign freq_2 = freq_r[2];
   assign freq_3 = freq_r[3];
   assign freq_4 = freq_r[4];
   assign freq_5 = freq_r[5];
   assign freq_6 = freq_r[6];
   assign freq_7 = freq_r[7];

endmodule
